cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 105 ++++++++++
 tb/tb_cdb_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Round-robin writeback arbiter: grants up to two requesters per cycle onto the CDB broadcast slots.
// Latency: payload on cdb_* one cycle after the valid/ready transfer; req_ready is combinational.
// Backpressure: ungranted requesters hold their request; reset/flush drop all grants. Option: CDB_ARB_LSU_PRIO_EN.
package core_pkg;
    localparam int XLEN        = 32;
    localparam int LOG2_PREGS  = 6;
    localparam int ROB_ENTRIES = 32;
endpackage

module cdb_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int CDB_W     = 2,
    parameter int XLEN      = core_pkg::XLEN,
    parameter int PHYS_W    = core_pkg::LOG2_PREGS,
    parameter int ROB_IDX_W = $clog2(core_pkg::ROB_ENTRIES)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush_pipeline,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0][PHYS_W-1:0]      req_tag,
    input  logic [NUM_REQ-1:0][XLEN-1:0]        req_value,
    input  logic [NUM_REQ-1:0][ROB_IDX_W-1:0]   req_rob_idx,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic [CDB_W-1:0]                    cdb_valid,
    output logic [CDB_W-1:0][PHYS_W-1:0]        cdb_tag,
    output logic [CDB_W-1:0][XLEN-1:0]          cdb_value,
    output logic [CDB_W-1:0][ROB_IDX_W-1:0]     cdb_rob_idx
);
    localparam int              PTR_W     = $clog2(NUM_REQ);
    localparam logic [PTR_W:0]  NUM_REQ_P = (PTR_W+1)'(NUM_REQ);
`ifdef CDB_ARB_LSU_PRIO_EN
    localparam logic [PTR_W-1:0] LSU_IDX  = PTR_W'(NUM_REQ-1);
`endif

    logic [PTR_W-1:0]            rr_ptr;
    logic [PTR_W-1:0]            rr_last;
    logic [PTR_W-1:0]            rr_next;
    logic                        rr_hit;
    logic                        block;
    logic                        scan_elig;
    logic [PTR_W:0]              scan_idx;
    logic [PTR_W:0]              ptr_inc;
    logic [CDB_W-1:0]            slot_vld;
    logic [CDB_W-1:0][PTR_W-1:0] slot_sel;

    always_comb begin
        req_ready = '0;
        slot_vld  = '0;
        slot_sel  = '0;
        rr_last   = rr_ptr;
        rr_hit    = 1'b0;
        scan_idx  = '0;
        scan_elig = 1'b1;
        block     = reset | flush_pipeline;
`ifdef CDB_ARB_LSU_PRIO_EN
        // LSU jumps the queue into slot 0 and stays out of the round-robin scan
        if (!block && req_valid[NUM_REQ-1]) begin
            req_ready[NUM_REQ-1] = 1'b1;
            slot_vld[0]          = 1'b1;
            slot_sel[0]          = LSU_IDX;
        end
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (scan_idx >= NUM_REQ_P) scan_idx = scan_idx - NUM_REQ_P;
`ifdef CDB_ARB_LSU_PRIO_EN
            scan_elig = (scan_idx[PTR_W-1:0] != LSU_IDX);
`endif
            if (!block && scan_elig && req_valid[scan_idx[PTR_W-1:0]] && !slot_vld[1]) begin
                req_ready[scan_idx[PTR_W-1:0]] = 1'b1;
                rr_last = scan_idx[PTR_W-1:0];
                rr_hit  = 1'b1;
                if (!slot_vld[0]) begin
                    slot_vld[0] = 1'b1;
                    slot_sel[0] = scan_idx[PTR_W-1:0];
                end else begin
                    slot_vld[1] = 1'b1;
                    slot_sel[1] = scan_idx[PTR_W-1:0];
                end
            end
        end
        ptr_inc = {1'b0, rr_last} + (PTR_W+1)'(1);
        rr_next = (ptr_inc == NUM_REQ_P) ? '0 : ptr_inc[PTR_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr      <= '0;
            cdb_valid   <= '0;
            cdb_tag     <= '0;
            cdb_value   <= '0;
            cdb_rob_idx <= '0;
        end else begin
            if (rr_hit) rr_ptr <= rr_next;
            // flush leaves slot_vld clear, so this also squashes the broadcast
            for (int s = 0; s < CDB_W; s++) begin
                cdb_valid[s]   <= slot_vld[s];
                cdb_tag[s]     <= slot_vld[s] ? req_tag[slot_sel[s]]     : '0;
                cdb_value[s]   <= slot_vld[s] ? req_value[slot_sel[s]]   : '0;
                cdb_rob_idx[s] <= slot_vld[s] ? req_rob_idx[slot_sel[s]] : '0;
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus randomized traffic against a queue-based grant model.
module tb_cdb_arbiter;
    localparam int N  = 4;
    localparam int XL = core_pkg::XLEN;
    localparam int PW = core_pkg::LOG2_PREGS;
    localparam int RW = $clog2(core_pkg::ROB_ENTRIES);

`ifdef CDB_ARB_LSU_PRIO_EN
    localparam logic [N-1:0] ALL_C1 = 4'b1001, ALL_C2 = 4'b1010, WRAP_NEXT = 4'b1010, RST_NEXT = 4'b1001;
    localparam int T1A = 13, T1B = 10, T2A = 13, T2B = 11;
`else
    localparam logic [N-1:0] ALL_C1 = 4'b0011, ALL_C2 = 4'b1100, WRAP_NEXT = 4'b0110, RST_NEXT = 4'b0011;
    localparam int T1A = 10, T1B = 11, T2A = 12, T2B = 13;
`endif

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     flush_pipeline;
    logic [N-1:0]             req_valid;
    logic [N-1:0][PW-1:0]     req_tag;
    logic [N-1:0][XL-1:0]     req_value;
    logic [N-1:0][RW-1:0]     req_rob_idx;
    logic [N-1:0]             req_ready;
    logic [1:0]               cdb_valid;
    logic [1:0][PW-1:0]       cdb_tag;
    logic [1:0][XL-1:0]       cdb_value;
    logic [1:0][RW-1:0]       cdb_rob_idx;

    cdb_arbiter dut (
        .clk(clk), .reset(reset), .flush_pipeline(flush_pipeline),
        .req_valid(req_valid), .req_tag(req_tag), .req_value(req_value), .req_rob_idx(req_rob_idx),
        .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_value(cdb_value), .cdb_rob_idx(cdb_rob_idx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int m_ptr    = 0;
    logic [N-1:0]       exp_ready, obs_ready;
    logic [1:0]         exp_vld;
    logic [1:0][PW-1:0] exp_tag;
    logic [1:0][XL-1:0] exp_value;
    logic [1:0][RW-1:0] exp_rob;

    // Valid requesters in rotated order from ptr; the first two take the slots.
    function automatic void model_grant(input logic [N-1:0] v, input int ptr, input logic blk,
                                        output int g0, output int g1, output int last_rr);
        int cand[$];
        g0 = -1; g1 = -1; last_rr = -1;
        if (blk) return;
`ifdef CDB_ARB_LSU_PRIO_EN
        if (v[N-1]) g0 = N-1;
`endif
        for (int k = 0; k < N; k++) begin
            int r;
            r = (ptr + k) % N;
`ifdef CDB_ARB_LSU_PRIO_EN
            if (r == N-1) continue;
`endif
            if (v[r]) cand.push_back(r);
        end
        foreach (cand[j]) begin
            if (g0 < 0) begin g0 = cand[j]; last_rr = cand[j]; end
            else if (g1 < 0) begin g1 = cand[j]; last_rr = cand[j]; end
        end
    endfunction

    // One clock: record model expectations, sample req_ready mid-cycle, advance to just after the edge.
    task automatic tick();
        int g0, g1, lr;
        int g[2];
        model_grant(req_valid, m_ptr, reset | flush_pipeline, g0, g1, lr);
        g[0] = g0; g[1] = g1;
        exp_ready = '0; exp_vld = '0; exp_tag = '0; exp_value = '0; exp_rob = '0;
        for (int s = 0; s < 2; s++) begin
            if (g[s] >= 0) begin
                exp_ready[g[s]] = 1'b1;
                exp_vld[s]      = 1'b1;
                exp_tag[s]      = req_tag[g[s]];
                exp_value[s]    = req_value[g[s]];
                exp_rob[s]      = req_rob_idx[g[s]];
            end
        end
        @(negedge clk);
        obs_ready = req_ready;
        @(posedge clk);
        #1;
        if (reset) m_ptr = 0;
        else if (lr >= 0) m_ptr = (lr + 1) % N;
    endtask

    task automatic apply_reset();
        reset = 1'b1; flush_pipeline = 1'b0; req_valid = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic set_payloads();
        for (int r = 0; r < N; r++) begin
            req_tag[r]     = PW'(10 + r);
            req_value[r]   = $urandom;
            req_rob_idx[r] = RW'(r + 1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; flush_pipeline = 1'b0; req_valid = '1;
        set_payloads();
        tick();
        n_checks++; if (obs_ready !== '0) begin n_fail++; $display("FAIL reset_ready got %b want 0", obs_ready); end
        n_checks++; if (cdb_valid !== '0) begin n_fail++; $display("FAIL reset_valid got %b want 0", cdb_valid); end
        n_checks++; if (cdb_tag !== '0 || cdb_value !== '0 || cdb_rob_idx !== '0) begin
            n_fail++; $display("FAIL reset_payload got tag=%h val=%h rob=%h want 0", cdb_tag, cdb_value, cdb_rob_idx); end
        reset = 1'b0; req_valid = '0;
    endtask

    task automatic test_single();
        req_valid = 4'b0001; req_tag[0] = PW'(5); req_value[0] = 32'hDEAD; req_rob_idx[0] = RW'(3);
        tick();
        n_checks++; if (obs_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready got %b want 0001", obs_ready); end
        n_checks++; if (cdb_valid !== 2'b01) begin n_fail++; $display("FAIL single_valid got %b want 01", cdb_valid); end
        n_checks++; if (cdb_tag[0] !== PW'(5) || cdb_value[0] !== 32'hDEAD || cdb_rob_idx[0] !== RW'(3)) begin
            n_fail++; $display("FAIL single_payload got tag=%0d val=%h rob=%0d want 5/dead/3", cdb_tag[0], cdb_value[0], cdb_rob_idx[0]); end
        n_checks++; if (cdb_tag[1] !== '0 || cdb_value[1] !== '0 || cdb_rob_idx[1] !== '0) begin
            n_fail++; $display("FAIL single_slot1 got tag=%0d val=%h rob=%0d want 0", cdb_tag[1], cdb_value[1], cdb_rob_idx[1]); end
        req_valid = '0;
        tick();
        n_checks++; if (cdb_valid !== 2'b00) begin n_fail++; $display("FAIL single_idle got %b want 00", cdb_valid); end
    endtask

    task automatic test_all_valid();
        apply_reset();
        set_payloads();
        req_valid = 4'b1111;
        tick();
        n_checks++; if (obs_ready !== ALL_C1) begin n_fail++; $display("FAIL all_c1_ready got %b want %b", obs_ready, ALL_C1); end
        n_checks++; if (cdb_valid !== 2'b11 || cdb_tag[0] !== PW'(T1A) || cdb_tag[1] !== PW'(T1B)) begin
            n_fail++; $display("FAIL all_c1_tags got v=%b %0d,%0d want 11 %0d,%0d", cdb_valid, cdb_tag[0], cdb_tag[1], T1A, T1B); end
        n_checks++; if (cdb_value !== exp_value || cdb_rob_idx !== exp_rob) begin
            n_fail++; $display("FAIL all_c1_data got %h/%h want %h/%h", cdb_value, cdb_rob_idx, exp_value, exp_rob); end
        tick();
        n_checks++; if (obs_ready !== ALL_C2) begin n_fail++; $display("FAIL all_c2_ready got %b want %b", obs_ready, ALL_C2); end
        n_checks++; if (cdb_valid !== 2'b11 || cdb_tag[0] !== PW'(T2A) || cdb_tag[1] !== PW'(T2B)) begin
            n_fail++; $display("FAIL all_c2_tags got v=%b %0d,%0d want 11 %0d,%0d", cdb_valid, cdb_tag[0], cdb_tag[1], T2A, T2B); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_wrap();
        apply_reset();
        set_payloads();
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b1001;
        tick();
        n_checks++; if (obs_ready !== 4'b1001) begin n_fail++; $display("FAIL wrap_ready got %b want 1001", obs_ready); end
        n_checks++; if (cdb_valid !== 2'b11 || cdb_tag[0] !== PW'(13) || cdb_tag[1] !== PW'(10)) begin
            n_fail++; $display("FAIL wrap_slots got v=%b %0d,%0d want 11 13,10", cdb_valid, cdb_tag[0], cdb_tag[1]); end
        req_valid = 4'b1111;
        tick();
        n_checks++; if (obs_ready !== WRAP_NEXT) begin n_fail++; $display("FAIL wrap_ptr_ready got %b want %b", obs_ready, WRAP_NEXT); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_flush();
        apply_reset();
        set_payloads();
        req_valid = 4'b0011;
        tick();
        flush_pipeline = 1'b1; req_valid = 4'b1111;
        #1;
        n_checks++; if (cdb_valid !== 2'b11 || cdb_tag[0] !== PW'(10) || cdb_tag[1] !== PW'(11)) begin
            n_fail++; $display("FAIL flush_held got v=%b %0d,%0d want 11 10,11", cdb_valid, cdb_tag[0], cdb_tag[1]); end
        tick();
        n_checks++; if (obs_ready !== '0) begin n_fail++; $display("FAIL flush_ready got %b want 0", obs_ready); end
        n_checks++; if (cdb_valid !== 2'b00 || cdb_tag !== '0) begin
            n_fail++; $display("FAIL flush_squash got v=%b tag=%h want 00/0", cdb_valid, cdb_tag); end
        flush_pipeline = 1'b0;
        tick();
        n_checks++; if (obs_ready !== 4'b1100) begin n_fail++; $display("FAIL flush_ptr_hold got %b want 1100", obs_ready); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_payloads();
        req_valid = 4'b1111;
        tick();
        reset = 1'b1;
        tick();
        n_checks++; if (obs_ready !== '0) begin n_fail++; $display("FAIL rstmid_ready got %b want 0", obs_ready); end
        n_checks++; if (cdb_valid !== '0 || cdb_tag !== '0 || cdb_value !== '0 || cdb_rob_idx !== '0) begin
            n_fail++; $display("FAIL rstmid_cdb got v=%b tag=%h val=%h rob=%h want 0", cdb_valid, cdb_tag, cdb_value, cdb_rob_idx); end
        reset = 1'b0;
        tick();
        n_checks++; if (obs_ready !== RST_NEXT) begin n_fail++; $display("FAIL rstmid_resume got %b want %b", obs_ready, RST_NEXT); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_random();
        apply_reset();
        for (int r = 0; r < N; r++) begin
            req_valid[r] = 1'b0; req_tag[r] = '0; req_value[r] = '0; req_rob_idx[r] = '0;
        end
        for (int c = 0; c < 400; c++) begin
            reset          = ($urandom_range(0, 99) < 2);
            flush_pipeline = ($urandom_range(0, 99) < 5);
            tick();
            n_checks++; if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready c=%0d got %b want %b", c, obs_ready, exp_ready); end
            n_checks++; if (cdb_valid !== exp_vld) begin n_fail++; $display("FAIL rnd_valid c=%0d got %b want %b", c, cdb_valid, exp_vld); end
            n_checks++; if (cdb_tag !== exp_tag) begin n_fail++; $display("FAIL rnd_tag c=%0d got %h want %h", c, cdb_tag, exp_tag); end
            n_checks++; if (cdb_value !== exp_value) begin n_fail++; $display("FAIL rnd_value c=%0d got %h want %h", c, cdb_value, exp_value); end
            n_checks++; if (cdb_rob_idx !== exp_rob) begin n_fail++; $display("FAIL rnd_rob c=%0d got %h want %h", c, cdb_rob_idx, exp_rob); end
            // Ungranted requests stay put; the rest draw fresh work. Narrow tags force duplicates.
            for (int r = 0; r < N; r++) begin
                if (!(req_valid[r] && !exp_ready[r])) begin
                    req_valid[r]   = ($urandom_range(0, 99) < 60);
                    req_tag[r]     = PW'($urandom_range(0, 7));
                    req_value[r]   = $urandom;
                    req_rob_idx[r] = RW'($urandom);
                end
            end
        end
        reset = 1'b0; flush_pipeline = 1'b0; req_valid = '0;
    endtask

    initial begin
        reset = 1'b1; flush_pipeline = 1'b0; req_valid = '0;
        req_tag = '0; req_value = '0; req_rob_idx = '0;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_all_valid();
        test_wrap();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
